// File: rtl/vu_pkg.sv
// rtl/vu_pkg.sv - shared widths, default constants and helpers for the VU level meter
package vu_pkg;

  localparam int ADC_W    = 12;
  localparam int LVL_W    = 11;
  localparam int N_LEDS   = 8;
  localparam int LED_STEP = 256;

  localparam int MIDSCALE_DEF    = 2048;
  localparam int DECAY_TICKS_DEF = 125000;
  localparam int DECAY_STEP_DEF  = 16;
  localparam int HOLD_TICKS_DEF  = 6250000;

  // Largest envelope value; a full-scale negative swing (code 0) would be 2048.
  localparam logic [ADC_W-1:0] MAG_MAX = ADC_W'((1 << LVL_W) - 1);

  // Distance of an ADC code from the bias point, clamped to the envelope range.
  function automatic logic [LVL_W-1:0] magnitude(input logic [ADC_W-1:0] code,
                                                 input logic [ADC_W-1:0] mid);
    logic [ADC_W-1:0] diff;
    diff = (code >= mid) ? (code - mid) : (mid - code);
    return (diff > MAG_MAX) ? MAG_MAX[LVL_W-1:0] : diff[LVL_W-1:0];
  endfunction

  // Thermometer code: LED i is lit once the level rises above i*LED_STEP.
  function automatic logic [N_LEDS-1:0] thermometer(input logic [LVL_W-1:0] lvl);
    logic [N_LEDS-1:0] bar;
    bar = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      bar[i] = (lvl > LVL_W'(i * LED_STEP));
    end
    return bar;
  endfunction

  // One-hot of the highest lit LED; zero when the bar is dark.
  function automatic logic [N_LEDS-1:0] top_onehot(input logic [N_LEDS-1:0] bar);
    logic [N_LEDS-1:0] dot;
    dot = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (bar[i]) begin
        dot    = '0;
        dot[i] = 1'b1;
      end
    end
    return dot;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - free-running modulo counter emitting a one-cycle tick at its terminal count
module tick_timer
  import vu_pkg::*;
#(
  parameter int TICKS = DECAY_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int          W    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] count;

  assign tick = (count == LAST);

  // Count 0..TICKS-1 and wrap on the tick cycle; never restarted from outside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/vu_level_meter.sv
// rtl/vu_level_meter.sv - VU meter: magnitude, attack/decay envelope, LED bar; peak dot under VU_PEAK_HOLD_EN
module vu_level_meter
  import vu_pkg::*;
#(
  parameter int MIDSCALE    = MIDSCALE_DEF,
  parameter int DECAY_TICKS = DECAY_TICKS_DEF,
  parameter int DECAY_STEP  = DECAY_STEP_DEF,
  parameter int HOLD_TICKS  = HOLD_TICKS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADC_W-1:0]  sample,
  input  logic              sample_valid,
  output logic [LVL_W-1:0]  level,
  output logic [N_LEDS-1:0] leds,
  output logic [N_LEDS-1:0] peak_led
);

  localparam logic [ADC_W-1:0] MID  = ADC_W'(MIDSCALE);
  localparam logic [LVL_W-1:0] STEP = LVL_W'(DECAY_STEP);

  logic [LVL_W-1:0] mag;
  logic             mag_valid;
  logic             decay_tick;

  tick_timer #(
    .TICKS (DECAY_TICKS)
  ) u_decay_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (decay_tick)
  );

  // Stage 1: capture the rectified, clamped sample; every strobe is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag       <= '0;
      mag_valid <= 1'b0;
    end else begin
      mag_valid <= sample_valid;
      if (sample_valid) begin
        mag <= magnitude(sample, MID);
      end
    end
  end

  // Stage 2: instant attack; otherwise linear decay floored at zero. Attack swallows a coincident tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else if (mag_valid && (mag > level)) begin
      level <= mag;
    end else if (decay_tick) begin
      level <= (level > STEP) ? (level - STEP) : '0;
    end
  end

  // Stage 3: thermometer bar from the envelope.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds <= '0;
    end else begin
      leds <= thermometer(level);
    end
  end

`ifdef VU_PEAK_HOLD_EN
  localparam int               HOLD_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  logic [HOLD_W-1:0] hold_count;
  logic [N_LEDS-1:0] top_dot;

  // One-hot values order the same way as LED indices, so a plain compare finds a higher peak.
  assign top_dot = top_onehot(leds);

  // Peak dot: jump up immediately, otherwise re-sample the bar each time the hold runs out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_led   <= '0;
      hold_count <= '0;
    end else if ((top_dot > peak_led) || (hold_count == '0)) begin
      peak_led   <= top_dot;
      hold_count <= HOLD_LAST;
    end else begin
      hold_count <= hold_count - HOLD_W'(1);
    end
  end
`else
  assign peak_led = '0;
`endif

endmodule

// File: tb/tb_vu_level_meter.sv
// tb/tb_vu_level_meter.sv - randomized self-checking bench for vu_level_meter against a behavioural model
module tb_vu_level_meter;

  localparam int T    = 10;
  localparam int STEP = 16;
  localparam int H    = 20;
  localparam int MID  = 2048;
`ifdef VU_PEAK_HOLD_EN
  localparam logic [7:0] PEAK_TOP  = 8'h80;
  localparam logic [7:0] PEAK_LATE = 8'h02;
`else
  localparam logic [7:0] PEAK_TOP  = 8'h00;
  localparam logic [7:0] PEAK_LATE = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic [10:0] level;
  logic [7:0]  leds;
  logic [7:0]  peak_led;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vu_level_meter #(
    .MIDSCALE    (MID),
    .DECAY_TICKS (T),
    .DECAY_STEP  (STEP),
    .HOLD_TICKS  (H)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample       (sample),
    .sample_valid (sample_valid),
    .level        (level),
    .leds         (leds),
    .peak_led     (peak_led)
  );

  // Reference model: elapsed-cycle decay schedule, abs/min arithmetic, LED count by division.
  logic [10:0] m_level;
  logic [7:0]  m_leds;
  logic [7:0]  m_peak;
  int          m_cnt, m_mag, m_hold, m_held;
  bit          m_mv;

  always @(posedge clk or posedge reset) begin : model
    int tk, nlvl, n, p, s;
    if (reset) begin
      m_level = '0; m_leds = '0; m_peak = '0;
      m_cnt = 0; m_mag = 0; m_mv = 0; m_hold = 0; m_held = -1;
    end else begin
      tk   = (m_cnt == T - 1);
      nlvl = m_level;
      if (m_mv && m_mag > m_level) nlvl = m_mag;
      else if (tk) nlvl = (m_level > STEP) ? m_level - STEP : 0;
      m_cnt = tk ? 0 : m_cnt + 1;
`ifdef VU_PEAK_HOLD_EN
      p = -1;
      for (int i = 0; i < 8; i++) if (m_leds[i]) p = i;
      if (p > m_held || m_hold == 0) begin
        m_held = p;
        m_hold = H - 1;
      end else begin
        m_hold = m_hold - 1;
      end
      m_peak = (m_held < 0) ? 8'h00 : 8'(1 << m_held);
`endif
      n = (m_level + 255) / 256;
      if (n > 8) n = 8;
      m_leds  = 8'((1 << n) - 1);
      m_level = 11'(nlvl);
      if (sample_valid) begin
        s     = int'(sample) - MID;
        m_mag = (s < 0) ? -s : s;
        if (m_mag > 2047) m_mag = 2047;
      end
      m_mv = sample_valid;
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    sample_valid = 1'b0;
    sample = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    sample = 12'd3548; sample_valid = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    total++;
    if (level !== 11'd1500 || level !== m_level) begin
      bad++; $display("FAIL reset_preload level=%0d required=1500 model=%0d", level, m_level);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (level !== 11'd0 || leds !== 8'h00 || peak_led !== 8'h00) begin
      bad++; $display("FAIL reset_async level=%0d leds=%h peak=%h required 0/00/00", level, leds, peak_led);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    sample = 12'd3048; sample_valid = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    total++;
    if (level !== 11'd1000 || level !== m_level) begin
      bad++; $display("FAIL reset_first_level level=%0d required=1000 model=%0d", level, m_level);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (leds !== 8'h0F || leds !== m_leds) begin
      bad++; $display("FAIL reset_first_leds leds=%h required=0f model=%h", leds, m_leds);
    end
    next_cycle();
  endtask

  task automatic test_magnitude;
    logic [11:0] codes [3];
    logic [10:0] lv    [3];
    logic [7:0]  bars  [3];
    codes = '{12'd2048, 12'd0, 12'd4095};
    lv    = '{11'd0, 11'd2047, 11'd2047};
    bars  = '{8'h00, 8'hFF, 8'hFF};
    for (int k = 0; k < 3; k++) begin
      if (k != 1) do_reset();
      sample = codes[k]; sample_valid = 1'b1;
      next_cycle();
      sample_valid = 1'b0;
      next_cycle();
      @(negedge clk);
      total++;
      if (level !== lv[k] || level !== m_level) begin
        bad++; $display("FAIL mag_level code=%0d level=%0d required=%0d", codes[k], level, lv[k]);
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (leds !== bars[k] || leds !== m_leds) begin
        bad++; $display("FAIL mag_leds code=%0d leds=%h required=%h", codes[k], leds, bars[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_attack_hold;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      sample_valid = (c == 0 || c == 2);
      sample = (c == 0) ? 12'd3048 : 12'd2548;
      @(negedge clk);
      if (c >= 2) begin
        total++;
        if (level !== 11'd1000 || level !== m_level || leds !== m_leds) begin
          bad++; $display("FAIL attack_hold cycle=%0d level=%0d required=1000 leds=%h model=%h", c, level, leds, m_leds);
        end
      end
      next_cycle();
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_decay;
    int drops;
    logic [10:0] prev;
    drops = 0;
    do_reset();
    sample = 12'd3048; sample_valid = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    prev = level;
    next_cycle();
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      total++;
      if (level !== m_level || leds !== m_leds || peak_led !== m_peak) begin
        bad++; $display("FAIL decay_track cycle=%0d level=%0d leds=%h peak=%h model %0d/%h/%h", c, level, leds, peak_led, m_level, m_leds, m_peak);
      end
      if (level != prev) begin
        drops++;
        total++;
        if (!((prev - level == 11'd16) || (prev < 11'd16 && level == 11'd0))) begin
          bad++; $display("FAIL decay_step from=%0d to=%0d required step 16 or floor 0", prev, level);
        end
      end
      prev = level;
      next_cycle();
    end
    total++;
    if (level !== 11'd0) begin
      bad++; $display("FAIL decay_floor level=%0d required=0", level);
    end
    total++;
    if (drops != 63) begin
      bad++; $display("FAIL decay_count steps=%0d required=63", drops);
    end
  endtask

  task automatic test_collision;
    int waited;
    do_reset();
    sample = 12'd2148; sample_valid = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    waited = 0;
    while (m_cnt != T - 2 && waited < 2 * T) begin
      next_cycle();
      waited++;
    end
    total++;
    if (m_cnt != T - 2) begin
      bad++; $display("FAIL collision_align count=%0d required=%0d", m_cnt, T - 2);
    end
    sample = 12'd2548; sample_valid = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    next_cycle();
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      total++;
      if (c < 12 && (level !== 11'd500 || level !== m_level)) begin
        bad++; $display("FAIL collision_hold cycle=%0d level=%0d required=500", c, level);
      end else if (c == 12 && (level !== 11'd484 || level !== m_level)) begin
        bad++; $display("FAIL collision_next_tick level=%0d required=484", level);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] codes [4];
    codes = '{12'd2548, 12'd3048, 12'd2200, 12'd548};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      sample_valid = (c < 4);
      sample = (c < 4) ? codes[c] : 12'd0;
      @(negedge clk);
      total++;
      if (level !== m_level || leds !== m_leds || peak_led !== m_peak) begin
        bad++; $display("FAIL b2b_track cycle=%0d level=%0d leds=%h model %0d/%h", c, level, leds, m_level, m_leds);
      end
      if (c == 2 || c == 5) begin
        total++;
        if (level !== ((c == 2) ? 11'd500 : 11'd1500)) begin
          bad++; $display("FAIL b2b_level cycle=%0d level=%0d required=%0d", c, level, (c == 2) ? 500 : 1500);
        end
      end
      if (c == 6) begin
        total++;
        if (leds !== 8'h3F) begin
          bad++; $display("FAIL b2b_leds leds=%h required=3f", leds);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_peak_hold;
    do_reset();
    sample = 12'd0; sample_valid = 1'b1;
    for (int c = 0; c < 1050; c++) begin
      @(negedge clk);
      total++;
      if (level !== m_level || leds !== m_leds || peak_led !== m_peak) begin
        bad++; $display("FAIL peak_track cycle=%0d level=%0d leds=%h peak=%h model %0d/%h/%h", c, level, leds, peak_led, m_level, m_leds, m_peak);
      end
      if (c == 4 || c == 23) begin
        total++;
        if (peak_led !== PEAK_TOP) begin
          bad++; $display("FAIL peak_top cycle=%0d peak=%h required=%h", c, peak_led, PEAK_TOP);
        end
      end
      next_cycle();
      sample_valid = 1'b0;
    end
    @(negedge clk);
    total++;
    if (leds !== 8'h03 || peak_led !== PEAK_LATE) begin
      bad++; $display("FAIL peak_late leds=%h peak=%h required 03/%h", leds, peak_led, PEAK_LATE);
    end
    next_cycle();
  endtask

  task automatic test_random;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      sample_valid = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 0) sample = 12'($urandom_range(0, 4095));
      else sample = 12'(MID - 300 + $urandom_range(0, 600));
      @(negedge clk);
      total++;
      if (level !== m_level || leds !== m_leds || peak_led !== m_peak) begin
        bad++; $display("FAIL random cycle=%0d level=%0d leds=%h peak=%h model %0d/%h/%h", c, level, leds, peak_led, m_level, m_leds, m_peak);
      end
      next_cycle();
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_magnitude();
    test_attack_hold();
    test_decay();
    test_collision();
    test_back_to_back();
    test_peak_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
